ami_resp_router: RTL and testbench

//  Routes AMI read responses from the memory system back to the correct requester: AOS-internal or application.

---
 rtl/ami_resp_router.sv | 110 +++++++++++
 tb/tb_ami_resp_router.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/ami_resp_router.sv
// AMI read-response router: records the source of each issued read in an in-order
// tag FIFO and steers each returning response to that source.

package ami_pkg;
    localparam int AMI_DATA_W = 64;
    localparam int AMI_SIZE_W = 6;

    typedef struct packed {
        logic                  valid;
        logic [AMI_DATA_W-1:0] data;
        logic [AMI_SIZE_W-1:0] size;
    } ami_response_t;
endpackage

module ami_resp_router
    import ami_pkg::*;
#(
    parameter int LOG_DEPTH = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 issue_fire,
    input  logic                 issue_is_write,
    input  logic                 issue_src,
    output logic                 issue_stall,
    input  ami_response_t        mem_resps,
    output logic                 mem_resp_grants,
    output ami_response_t        mem_resps_internal,
    input  logic                 mem_resp_grants_internal,
    output ami_response_t        mem_resps_app,
    input  logic                 mem_resp_grants_app,
    output logic [LOG_DEPTH:0]   outstanding,
    output logic                 err_overflow,
    output logic                 err_orphan
);

    localparam int DEPTH = 1 << LOG_DEPTH;
    localparam int CNT_W = LOG_DEPTH + 1;

    logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [LOG_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     outstanding_q, outstanding_d;
    logic                 err_overflow_q, err_overflow_d;
    logic                 err_orphan_q, err_orphan_d;
    logic                 tag_q [DEPTH];

    logic full, empty, head, is_read, push, pop;

    // Full/empty come from registered state only, so issue_stall has no path from issue_*.
    assign full    = (outstanding_q == CNT_W'(DEPTH));
    assign empty   = (outstanding_q == '0);
    assign head    = tag_q[rd_ptr_q];
    assign is_read = issue_fire && !issue_is_write;
    assign push    = is_read && !full;

    always_comb begin
        mem_resps_internal = '0;
        mem_resps_app      = '0;
        // With nothing outstanding every response is an orphan and is discarded.
        mem_resp_grants    = 1'b1;
        if (!empty) begin
            if (head) begin
                mem_resps_app   = mem_resps;
                mem_resp_grants = mem_resp_grants_app;
            end else begin
                mem_resps_internal = mem_resps;
                mem_resp_grants    = mem_resp_grants_internal;
            end
        end
    end

    assign pop = !empty && mem_resps.valid && mem_resp_grants;

    always_comb begin
        wr_ptr_d       = wr_ptr_q + LOG_DEPTH'(push);
        rd_ptr_d       = rd_ptr_q + LOG_DEPTH'(pop);
        outstanding_d  = outstanding_q + CNT_W'(push) - CNT_W'(pop);
        err_overflow_d = err_overflow_q | (is_read && full);
        err_orphan_d   = err_orphan_q | (empty && mem_resps.valid);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            outstanding_q  <= '0;
            err_overflow_q <= 1'b0;
            err_orphan_q   <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            outstanding_q  <= outstanding_d;
            err_overflow_q <= err_overflow_d;
            err_orphan_q   <= err_orphan_d;
        end
    end

    // NOTE: tag storage is not reset; entries are only read after being written, and an
    // unreset array maps onto plain RAM/regfile cells.
    always_ff @(posedge clk) begin
        if (push) tag_q[wr_ptr_q] <= issue_src;
    end

    assign issue_stall  = full;
    assign outstanding  = outstanding_q;
    assign err_overflow = err_overflow_q;
    assign err_orphan   = err_orphan_q;

endmodule

// File: tb/tb_ami_resp_router.sv
// Self-checking bench for ami_resp_router: directed scenarios plus randomized traffic,
// all compared against a queue-based model of outstanding read sources.

module tb_ami_resp_router;
    import ami_pkg::*;

    localparam int LD    = 2;
    localparam int DEPTH = 1 << LD;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          issue_fire = 1'b0, issue_is_write = 1'b0, issue_src = 1'b0;
    logic          issue_stall;
    ami_response_t mem_resps = '0;
    logic          mem_resp_grants;
    ami_response_t mem_resps_internal, mem_resps_app;
    logic          mem_resp_grants_internal = 1'b0, mem_resp_grants_app = 1'b0;
    logic [LD:0]   outstanding;
    logic          err_overflow, err_orphan;

    ami_resp_router #(.LOG_DEPTH(LD)) dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .issue_fire               (issue_fire),
        .issue_is_write           (issue_is_write),
        .issue_src                (issue_src),
        .issue_stall              (issue_stall),
        .mem_resps                (mem_resps),
        .mem_resp_grants          (mem_resp_grants),
        .mem_resps_internal       (mem_resps_internal),
        .mem_resp_grants_internal (mem_resp_grants_internal),
        .mem_resps_app            (mem_resps_app),
        .mem_resp_grants_app      (mem_resp_grants_app),
        .outstanding              (outstanding),
        .err_overflow             (err_overflow),
        .err_orphan               (err_orphan)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_passed = 0;

    // Model: sources of reads still awaiting a response, oldest first.
    bit src_q[$];
    bit m_ovf = 1'b0;
    bit m_orph = 1'b0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else n_passed++;
    endtask

    task automatic step(input logic f, input logic w, input logic s, input logic v,
                        input logic gi, input logic ga);
        ami_response_t r, e_int, e_app;
        logic e_g;
        bit do_pop;
        r.valid = v;
        r.data  = {$urandom, $urandom};
        r.size  = AMI_SIZE_W'($urandom);
        @(negedge clk);
        issue_fire = f; issue_is_write = w; issue_src = s;
        mem_resps = r; mem_resp_grants_internal = gi; mem_resp_grants_app = ga;
        #1;
        e_int = '0; e_app = '0; e_g = 1'b1;
        if (src_q.size() != 0) begin
            if (src_q[0]) begin e_app = r; e_g = ga; end
            else          begin e_int = r; e_g = gi; end
        end
        check("resp_internal", 128'(mem_resps_internal), 128'(e_int));
        check("resp_app", 128'(mem_resps_app), 128'(e_app));
        check("resp_grant", 128'(mem_resp_grants), 128'(e_g));
        check("stall", 128'(issue_stall), 128'(src_q.size() == DEPTH));
        check("outstanding", 128'(outstanding), 128'(src_q.size()));
        check("err_overflow", 128'(err_overflow), 128'(m_ovf));
        check("err_orphan", 128'(err_orphan), 128'(m_orph));
        @(posedge clk);
        do_pop = (src_q.size() != 0) && v && e_g;
        if (src_q.size() == 0 && v) m_orph = 1'b1;
        if (f && !w) begin
            if (src_q.size() == DEPTH) m_ovf = 1'b1;
            else src_q.push_back(s);
        end
        if (do_pop) void'(src_q.pop_front());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        issue_fire = 0; issue_is_write = 0; issue_src = 0;
        mem_resps = '0; mem_resp_grants_internal = 0; mem_resp_grants_app = 0;
        rst_n = 1'b0;
        #1;
        check("rst_outstanding", 128'(outstanding), 128'(0));
        check("rst_err_orphan", 128'(err_orphan), 128'(0));
        check("rst_err_overflow", 128'(err_overflow), 128'(0));
        check("rst_stall", 128'(issue_stall), 128'(0));
        src_q.delete(); m_ovf = 1'b0; m_orph = 1'b0;
        #3 rst_n = 1'b1;
    endtask

    initial begin
        #12 rst_n = 1'b1;
        // Reset state with no stimulus.
        idle(2);

        // Reads 0,1,1,0 then four responses with both grants high.
        step(1, 0, 0, 0, 0, 0); step(1, 0, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0); step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1, 1);
        idle(1);

        // A write is not tracked; the following read is.
        step(1, 1, 1, 0, 0, 0); step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 1);
        idle(1);

        // Fill, then overflow, then pop plus read while full.
        for (int i = 0; i < DEPTH; i++) step(1, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 1, 1);
        while (src_q.size() != 0) step(0, 0, 0, 1, 1, 1);
        apply_reset();

        // App head held by app backpressure; internal grant must be ignored.
        step(1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 0, 1);
        idle(1);

        // Orphan response, then reset with reads outstanding.
        step(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, i[0], 0, 0, 0);
        idle(1);
        apply_reset();
        step(0, 0, 0, 1, 1, 1);
        apply_reset();

        // Randomized traffic with occasional mid-operation reset.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) apply_reset();
            step(logic'($urandom_range(0, 99) < 45), logic'($urandom_range(0, 3) == 0),
                 logic'($urandom), logic'($urandom_range(0, 99) < 50),
                 logic'($urandom_range(0, 99) < 70), logic'($urandom_range(0, 99) < 70));
        end

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
